// File: rtl/tdm_demux8.sv
// Receive side of an 8-slot TDM link: rebuilds parallel frames from a serial
// bit stream, using frame_sync to acquire alignment and slot wrap to keep it.
module tdm_demux8 #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [NUM_CH-1:0] dout,
  output logic              dout_valid,
  output logic [SEL_W-1:0]  slot,
  output logic              locked,
  output logic              sync_err
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] FIRST_DATA = SEL_W'(1);

  state_e            state_q;
  logic [SEL_W-1:0]  slot_q;
  logic [NUM_CH-1:0] shadow_q;
  logic [NUM_CH-1:0] dout_q;
  logic              dout_valid_q;
  logic              sync_err_q;
  logic              locked_q;

  logic [SEL_W-1:0]  slot_d;
  logic [NUM_CH-1:0] frame_d;
  logic [NUM_CH-1:0] restart_d;

  // NUM_CH is a power of two, so the natural counter overflow is the slot wrap.
  always_comb begin
    slot_d    = slot_q + 1'b1;
    frame_d   = {din, shadow_q[NUM_CH-2:0]};
    restart_d = {{(NUM_CH-1){1'b0}}, din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      slot_q       <= '0;
      shadow_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      sync_err_q   <= 1'b0;
      if (din_valid) begin
        case (state_q)
          HUNT: begin
            if (frame_sync) begin
              shadow_q <= restart_d;
              slot_q   <= FIRST_DATA;
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            // A sync anywhere but slot 0 (including the last slot) aborts the frame.
            if (frame_sync && (slot_q != '0)) begin
              sync_err_q <= 1'b1;
              shadow_q   <= restart_d;
              slot_q     <= FIRST_DATA;
            end else begin
              shadow_q[slot_q] <= din;
              slot_q           <= slot_d;
              if (slot_q == LAST_SLOT) begin
                dout_q       <= frame_d;
                dout_valid_q <= 1'b1;
              end
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            slot_q   <= '0;
          end
        endcase
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign slot       = slot_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: acquisition, flywheel framing, misaligned
// sync handling and asynchronous reset.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       locked;
  logic       sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux8 #(.NUM_CH(8), .SEL_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, then leave outputs settled just after the rising edge.
  task automatic applyStimulus(input logic d, input logic fs, input logic v);
    @(negedge clk);
    din        = d;
    frame_sync = fs;
    din_valid  = v;
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    #12;
    checks++;
    if (dout !== 8'h00) begin $display("[TB] FAIL reset_dout: got %h expected %h", dout, 8'h00); errors++; end
    checks++;
    if (slot !== 3'd0) begin $display("[TB] FAIL reset_slot: got %0d expected 0", slot); errors++; end
    checks++;
    if (locked !== 1'b0) begin $display("[TB] FAIL reset_locked: got %b expected 0", locked); errors++; end
    checks++;
    if (dout_valid !== 1'b0 || sync_err !== 1'b0) begin
      $display("[TB] FAIL reset_pulses: got dout_valid=%b sync_err=%b expected 0 0", dout_valid, sync_err);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 1'b0, 1'b1);
      checks++;
      if (slot !== 3'd0 || locked !== 1'b0 || dout_valid !== 1'b0) begin
        $display("[TB] FAIL hunt_bit%0d: got slot=%0d locked=%b dout_valid=%b expected 0 0 0",
                 i, slot, locked, dout_valid);
        errors++;
      end
    end
    checks++;
    if (dout !== 8'h00) begin $display("[TB] FAIL hunt_dout: got %h expected %h", dout, 8'h00); errors++; end
  endtask

  task automatic test_basic_frame();
    logic [7:0] frame;
    logic [2:0] expSlot;
    frame = 8'hD6;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(frame[i], (i == 0), 1'b1);
      expSlot = 3'((i + 1) % 8);
      checks++;
      if (dout_valid !== (i == 7) || slot !== expSlot || locked !== 1'b1) begin
        $display("[TB] FAIL basic_bit%0d: got dout_valid=%b slot=%0d locked=%b expected %b %0d 1",
                 i, dout_valid, slot, locked, (i == 7), expSlot);
        errors++;
      end
    end
    checks++;
    if (dout !== 8'hD6) begin $display("[TB] FAIL basic_dout: got %h expected %h", dout, 8'hD6); errors++; end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'hD6) begin
      $display("[TB] FAIL basic_hold: got dout_valid=%b dout=%h expected 0 d6", dout_valid, dout);
      errors++;
    end
  endtask

  task automatic test_flywheel();
    logic [7:0] frame;
    logic [2:0] expSlot;
    frame = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(frame[i], 1'b0, 1'b1);
      expSlot = 3'((i + 1) % 8);
      checks++;
      if (dout_valid !== (i == 7) || slot !== expSlot) begin
        $display("[TB] FAIL fly_bit%0d: got dout_valid=%b slot=%0d expected %b %0d",
                 i, dout_valid, slot, (i == 7), expSlot);
        errors++;
      end
      if (i < 7) begin
        for (int g = 0; g < 2; g++) begin
          // frame_sync without din_valid must be ignored.
          applyStimulus(1'b1, 1'b1, 1'b0);
          checks++;
          if (dout_valid !== 1'b0 || dout !== 8'hD6 || slot !== expSlot || sync_err !== 1'b0) begin
            $display("[TB] FAIL fly_gap%0d_%0d: got dout_valid=%b dout=%h slot=%0d sync_err=%b expected 0 d6 %0d 0",
                     i, g, dout_valid, dout, slot, sync_err, expSlot);
            errors++;
          end
        end
      end
    end
    checks++;
    if (dout !== 8'hA5) begin $display("[TB] FAIL fly_dout: got %h expected %h", dout, 8'hA5); errors++; end
  endtask

  task automatic test_misaligned();
    logic [6:0] tail;
    logic [2:0] expSlot;
    tail = 7'b1010110;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checks++;
    if (slot !== 3'd3) begin $display("[TB] FAIL mis_pre_slot: got %0d expected 3", slot); errors++; end
    applyStimulus(1'b1, 1'b1, 1'b1);
    checks++;
    if (sync_err !== 1'b1 || dout_valid !== 1'b0 || slot !== 3'd1 || locked !== 1'b1 || dout !== 8'hA5) begin
      $display("[TB] FAIL mis_sync: got sync_err=%b dout_valid=%b slot=%0d locked=%b dout=%h expected 1 0 1 1 a5",
               sync_err, dout_valid, slot, locked, dout);
      errors++;
    end
    for (int j = 0; j < 7; j++) begin
      applyStimulus(tail[j], 1'b0, 1'b1);
      expSlot = 3'((j + 2) % 8);
      checks++;
      if (sync_err !== 1'b0 || dout_valid !== (j == 6) || slot !== expSlot) begin
        $display("[TB] FAIL mis_bit%0d: got sync_err=%b dout_valid=%b slot=%0d expected 0 %b %0d",
                 j, sync_err, dout_valid, slot, (j == 6), expSlot);
        errors++;
      end
    end
    checks++;
    if (dout !== 8'hAD) begin $display("[TB] FAIL mis_dout: got %h expected %h", dout, 8'hAD); errors++; end
  endtask

  task automatic test_sync_last();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    checks++;
    if (slot !== 3'd7) begin $display("[TB] FAIL last_pre_slot: got %0d expected 7", slot); errors++; end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checks++;
    if (sync_err !== 1'b1 || dout_valid !== 1'b0 || slot !== 3'd1 || dout !== 8'hAD) begin
      $display("[TB] FAIL last_sync: got sync_err=%b dout_valid=%b slot=%0d dout=%h expected 1 0 1 ad",
               sync_err, dout_valid, slot, dout);
      errors++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checks++;
    if (sync_err !== 1'b0) begin $display("[TB] FAIL last_pulse: got sync_err=%b expected 0", sync_err); errors++; end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1);
    checks++;
    if (slot !== 3'd4) begin $display("[TB] FAIL arst_pre_slot: got %0d expected 4", slot); errors++; end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 8'h00 || locked !== 1'b0 || slot !== 3'd0) begin
      $display("[TB] FAIL arst_now: got dout=%h locked=%b slot=%0d expected 00 0 0", dout, locked, slot);
      errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    checks++;
    if (slot !== 3'd0 || locked !== 1'b0) begin
      $display("[TB] FAIL arst_hunt: got slot=%0d locked=%b expected 0 0", slot, locked);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] frames;
    frames = 16'h813C;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(frames[i], (i == 0), 1'b1);
      checks++;
      if (dout_valid !== (i == 7 || i == 15)) begin
        $display("[TB] FAIL b2b_valid%0d: got %b expected %b", i, dout_valid, (i == 7 || i == 15));
        errors++;
      end
      if (i == 7) begin
        checks++;
        if (dout !== 8'h3C) begin $display("[TB] FAIL b2b_dout0: got %h expected %h", dout, 8'h3C); errors++; end
      end
    end
    checks++;
    if (dout !== 8'h81 || slot !== 3'd0) begin
      $display("[TB] FAIL b2b_dout1: got dout=%h slot=%0d expected 81 0", dout, slot);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_flywheel();
    test_misaligned();
    test_sync_last();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Serial time-division demultiplexer: the receive end of an 8-channel TDM link whose transmit side is an 8:1 mux driven by a 3-bit slot select.
- Takes one bit per valid cycle plus a frame-sync marker and tracks the slot index internally.
- Steers each bit into its channel position and presents a complete 8-bit frame with a one-cycle valid strobe.
- Also flags sync misalignment.

Parameters:
- NUM_CH, 8, number of channels/slots per frame; must be a power of two ≥ 2.
- SEL_W, 3, slot index width; must equal log2(NUM_CH).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit for the current slot
- din_valid  input  1  din and frame_sync are sampled only when high
- frame_sync  input  1  marks the current valid bit as slot 0 of a new frame
- dout  output  NUM_CH  last completed frame; bit k = slot k
- dout_valid  output  1  one-cycle pulse when dout updates
- slot  output  SEL_W  slot index the next valid bit will be written to
- locked  output  1  high while in LOCKED state
- sync_err  output  1  one-cycle pulse on misaligned frame_sync

Behaviour:
- Reset (async, rst_n=0): state=HUNT, slot=0, shadow=0, dout=0, dout_valid=0, locked=0, sync_err=0. Deassertion takes effect on the next clk edge.
- Cycles with din_valid=0 change nothing except dout_valid and sync_err, which return to 0. frame_sync is ignored when din_valid=0.
- HUNT state:
  - Valid bits with frame_sync=0 are discarded; slot stays 0.
  - A valid bit with frame_sync=1 writes shadow[0]=din, sets slot=1, and moves to LOCKED (locked=1 from the next cycle).
- LOCKED, valid bit, frame_sync=0:
  - shadow[slot]=din; slot increments modulo NUM_CH.
  - When the written slot is NUM_CH-1: on the same edge, dout <= {din, shadow[NUM_CH-2:0]} and dout_valid=1 for one cycle; slot wraps to 0.
  - Flywheel: frame_sync is not required on later frames; slot wrap alone delimits frames.
- LOCKED, valid bit, frame_sync=1, slot==0: normal slot-0 write. No error.
- LOCKED, valid bit, frame_sync=1, slot!=0:
  - Partial frame is discarded (dout unchanged, no dout_valid).
  - sync_err=1 for one cycle.
  - shadow cleared, shadow[0]=din, slot=1. Remains LOCKED.
- Latency: dout/dout_valid appear on the clk edge that samples the last slot's bit, i.e. the output registers are valid the cycle after the last bit is presented.
- dout holds its value between frames. dout_valid and sync_err are never high for more than one consecutive cycle unless a new event occurs.
- Simultaneous events: frame_sync on the slot NUM_CH-1 position (slot==NUM_CH-1) is a misalignment. The error path wins: no dout_valid, sync_err=1.
- Reset mid-frame: partial shadow is lost, state returns to HUNT, dout cleared to 0.
- No back-pressure: every valid bit is accepted.

Test Plan:
- Reset/hunt: rst_n=0 then 1, feed 5 valid bits with frame_sync=0 -> slot=0, locked=0, dout=8'h00, no dout_valid.
- Basic frame: frame_sync=1 with first bit, then send 8'b1101_0110 LSB first (slot0=0, slot1=1, …, slot7=1) on consecutive valid cycles -> after the 8th bit, dout=8'hD6, dout_valid pulses exactly once, slot=0, locked=1.
- Gapped valid + flywheel: second frame 8'hA5 with din_valid low for 2 cycles between bits and no frame_sync -> dout=8'hA5, one dout_valid pulse; dout stays 8'hD6 until then.
- Misaligned sync: after 3 bits of a frame, assert frame_sync with din=1, then 7 more bits 0,1,1,0,1,0,1 -> sync_err pulses once at the misaligned bit, no dout_valid for the aborted frame, next dout=8'hAD.
- Sync on last slot: frame_sync with the 8th bit of a frame -> sync_err=1, dout_valid=0, slot=1.
- Async reset mid-frame: drop rst_n between clk edges after 4 bits -> dout=0, locked=0, slot=0 immediately, without waiting for clk.
